// File: rtl/mm_ctrl.sv
// mm_ctrl: multi-cycle memory-stage controller between ex and wb.
// Issues one registered load or store per instruction on a handshaked data bus and holds the
// pipeline with stall until bus_ack or a timeout. Formats load data (byte, half, word, LWL, LWR)
// and replicates store data with byte enables.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_access_type       M2R = load, R2M = store, other = no access
//   mem_access_size       BYTE, HALF, WORD, LEFT_WORD, RIGHT_WORD
//   mem_access_signed     sign-extend byte/half loads
//   mem_access_addr_i     byte address from ex
//   data_i                store data, LWL/LWR merge source (rt), or pass-through value
//   reg_addr_i            destination register
//   data_o                result to wb and bypass mux
//   bypass_reg_addr_mm    copy of reg_addr_i
//   stall                 freeze ex/mm pipeline registers
//   resp_valid            one-cycle pulse when an access completes
//   alignment_err         combinational misaligned half/word access flag
//   bus_err               one-cycle pulse (in the response cycle) on timeout
//   bus_addr/wdata/be     registered bus request (word-aligned address)
//   bus_read/bus_write    registered bus strobes
//   bus_rdata, bus_ack    bus response
module mm_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  mem_access_type,
   input  logic [2:0]  mem_access_size,
   input  logic        mem_access_signed,
   input  logic [31:0] mem_access_addr_i,
   input  logic [31:0] data_i,
   input  logic [4:0]  reg_addr_i,
   output logic [31:0] data_o,
   output logic [4:0]  bypass_reg_addr_mm,
   output logic        stall,
   output logic        resp_valid,
   output logic        alignment_err,
   output logic        bus_err,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   output logic        bus_read,
   output logic        bus_write,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);

   // Encodings shared with defs.v
   localparam logic [1:0] MEM_ACCESS_TYPE_M2R = 2'b01;
   localparam logic [1:0] MEM_ACCESS_TYPE_R2M = 2'b10;

   localparam logic [2:0] MEM_ACCESS_LENGTH_BYTE       = 3'd0;
   localparam logic [2:0] MEM_ACCESS_LENGTH_HALF       = 3'd1;
   localparam logic [2:0] MEM_ACCESS_LENGTH_WORD       = 3'd2;
   localparam logic [2:0] MEM_ACCESS_LENGTH_LEFT_WORD  = 3'd3;
   localparam logic [2:0] MEM_ACCESS_LENGTH_RIGHT_WORD = 3'd4;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      resp_q;
   logic             load_q;
   logic [2:0]       size_q;
   logic             signed_q;
   logic [1:0]       a_q;
   logic [31:0]      rt_q;

   logic        is_load, is_store, start, timeout;
   logic [1:0]  a;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [31:0] load_fmt;
   logic [7:0]  lane8;
   logic [15:0] lane16;

   assign a        = mem_access_addr_i[1:0];
   assign is_load  = (mem_access_type == MEM_ACCESS_TYPE_M2R);
   assign is_store = (mem_access_type == MEM_ACCESS_TYPE_R2M);

   assign alignment_err = (is_load | is_store) &
                          (((mem_access_size == MEM_ACCESS_LENGTH_HALF) & a[0]) |
                           ((mem_access_size == MEM_ACCESS_LENGTH_WORD) & (a != 2'b00)));

   assign start   = (is_load | is_store) & ~alignment_err & (state_q == StIdle);
   assign stall   = start | (state_q == StWait);
   assign timeout = (state_q == StWait) & ~bus_ack & (cnt_q == CNT_W'(TIMEOUT - 1));

   assign resp_valid         = (state_q == StResp);
   assign data_o             = (state_q == StResp) ? resp_q : data_i;
   assign bypass_reg_addr_mm = reg_addr_i;

   // Request formatting from the live inputs, registered on accept.
   // {~a, 3'b000} is (3-a)*8.
   always_comb begin
      be_new    = 4'b0000;
      wdata_new = 32'h0;
      unique case (mem_access_size)
         MEM_ACCESS_LENGTH_BYTE: begin
            be_new    = 4'b0001 << a;
            wdata_new = {4{data_i[7:0]}};
         end
         MEM_ACCESS_LENGTH_HALF: begin
            be_new    = a[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{data_i[15:0]}};
         end
         MEM_ACCESS_LENGTH_WORD: begin
            be_new    = 4'b1111;
            wdata_new = data_i;
         end
         MEM_ACCESS_LENGTH_LEFT_WORD: begin
            be_new    = {a[1] & a[0], a[1], a[1] | a[0], 1'b1};
            wdata_new = data_i >> {~a, 3'b000};
         end
         MEM_ACCESS_LENGTH_RIGHT_WORD: begin
            be_new    = {1'b1, ~(a[1] & a[0]), ~a[1], ~(a[1] | a[0])};
            wdata_new = data_i << {a, 3'b000};
         end
         default: ;
      endcase
   end

   // Load formatting from the latched request and the returning bus data.
   always_comb begin
      lane8    = bus_rdata[{a_q, 3'b000} +: 8];
      lane16   = bus_rdata[{a_q[1], 4'b0000} +: 16];
      load_fmt = 32'h0;
      unique case (size_q)
         MEM_ACCESS_LENGTH_BYTE:       load_fmt = {{24{signed_q & lane8[7]}}, lane8};
         MEM_ACCESS_LENGTH_HALF:       load_fmt = {{16{signed_q & lane16[15]}}, lane16};
         MEM_ACCESS_LENGTH_WORD:       load_fmt = bus_rdata;
         MEM_ACCESS_LENGTH_LEFT_WORD:  load_fmt = (bus_rdata << {~a_q, 3'b000}) |
                                                  (rt_q & ~(32'hFFFF_FFFF << {~a_q, 3'b000}));
         MEM_ACCESS_LENGTH_RIGHT_WORD: load_fmt = (bus_rdata >> {a_q, 3'b000}) |
                                                  (rt_q & ~(32'hFFFF_FFFF >> {a_q, 3'b000}));
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StWait;
         StWait:  if (bus_ack || timeout) state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         resp_q    <= 32'h0;
         load_q    <= 1'b0;
         size_q    <= 3'd0;
         signed_q  <= 1'b0;
         a_q       <= 2'b00;
         rt_q      <= 32'h0;
         bus_err   <= 1'b0;
         bus_addr  <= 32'h0;
         bus_wdata <= 32'h0;
         bus_be    <= 4'b0000;
         bus_read  <= 1'b0;
         bus_write <= 1'b0;
      end else begin
         state_q <= state_d;
         bus_err <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  load_q    <= is_load;
                  size_q    <= mem_access_size;
                  signed_q  <= mem_access_signed;
                  a_q       <= a;
                  rt_q      <= data_i;
                  cnt_q     <= '0;
                  bus_addr  <= {mem_access_addr_i[31:2], 2'b00};
                  bus_wdata <= is_store ? wdata_new : 32'h0;
                  bus_be    <= be_new;
                  bus_read  <= is_load;
                  bus_write <= is_store;
               end else begin
                  bus_read  <= 1'b0;
                  bus_write <= 1'b0;
               end
            end
            StWait: begin
               // Ack takes priority over a coinciding timeout.
               if (bus_ack) begin
                  bus_read  <= 1'b0;
                  bus_write <= 1'b0;
                  resp_q    <= load_q ? load_fmt : rt_q;
               end else if (timeout) begin
                  bus_read  <= 1'b0;
                  bus_write <= 1'b0;
                  resp_q    <= 32'h0;
                  bus_err   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mm_ctrl.sv
// Bench for mm_ctrl: directed cases plus random loads/stores. Expected responses are pushed into
// a scoreboard queue when an access is issued; a negedge monitor pops them on resp_valid.
module tb_mm_ctrl;

   localparam int unsigned TIMEOUT = 16;

   localparam logic [1:0] T_NONE = 2'b00;
   localparam logic [1:0] T_M2R  = 2'b01;
   localparam logic [1:0] T_R2M  = 2'b10;

   localparam logic [2:0] L_BYTE  = 3'd0;
   localparam logic [2:0] L_HALF  = 3'd1;
   localparam logic [2:0] L_WORD  = 3'd2;
   localparam logic [2:0] L_LEFT  = 3'd3;
   localparam logic [2:0] L_RIGHT = 3'd4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  mem_access_type = T_NONE;
   logic [2:0]  mem_access_size = L_WORD;
   logic        mem_access_signed = 1'b0;
   logic [31:0] mem_access_addr_i = 32'h0;
   logic [31:0] data_i = 32'h0;
   logic [4:0]  reg_addr_i = 5'd0;
   logic [31:0] data_o;
   logic [4:0]  bypass_reg_addr_mm;
   logic        stall, resp_valid, alignment_err, bus_err;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_read, bus_write;
   logic [31:0] bus_rdata = 32'h0;
   logic        bus_ack = 1'b0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t exp_q[$];

   mm_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .mem_access_type    (mem_access_type),
      .mem_access_size    (mem_access_size),
      .mem_access_signed  (mem_access_signed),
      .mem_access_addr_i  (mem_access_addr_i),
      .data_i             (data_i),
      .reg_addr_i         (reg_addr_i),
      .data_o             (data_o),
      .bypass_reg_addr_mm (bypass_reg_addr_mm),
      .stall              (stall),
      .resp_valid         (resp_valid),
      .alignment_err      (alignment_err),
      .bus_err            (bus_err),
      .bus_addr           (bus_addr),
      .bus_wdata          (bus_wdata),
      .bus_be             (bus_be),
      .bus_read           (bus_read),
      .bus_write          (bus_write),
      .bus_rdata          (bus_rdata),
      .bus_ack            (bus_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- reference model (byte-lane view) ----------------
   function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
      return w[i*8 +: 8];
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] sz, input int a);
      logic [3:0] r = 4'b0000;
      for (int j = 0; j < 4; j++) begin
         case (sz)
            L_BYTE:  r[j] = (j == a);
            L_HALF:  r[j] = ((j / 2) == (a / 2));
            L_WORD:  r[j] = 1'b1;
            L_LEFT:  r[j] = (j <= a);
            L_RIGHT: r[j] = (j >= a);
            default: r[j] = 1'b0;
         endcase
      end
      return r;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] sz, input int a,
                                               input logic [31:0] d);
      logic [31:0] r = 32'h0;
      for (int j = 0; j < 4; j++) begin
         case (sz)
            L_BYTE:  r[j*8 +: 8] = byte_of(d, 0);
            L_HALF:  r[j*8 +: 8] = byte_of(d, j % 2);
            L_WORD:  r[j*8 +: 8] = byte_of(d, j);
            L_LEFT:  r[j*8 +: 8] = (j <= a) ? byte_of(d, j + 3 - a) : 8'h00;
            L_RIGHT: r[j*8 +: 8] = (j >= a) ? byte_of(d, j - a) : 8'h00;
            default: r[j*8 +: 8] = 8'h00;
         endcase
      end
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] sz, input logic sg, input int a,
                                              input logic [31:0] rt, input logic [31:0] rd);
      logic [31:0] r = 32'h0;
      logic [7:0]  b;
      logic [15:0] h;
      case (sz)
         L_BYTE: begin
            b = byte_of(rd, a);
            r = (sg && b[7]) ? {24'hFF_FFFF, b} : {24'h0, b};
         end
         L_HALF: begin
            h = (a >= 2) ? rd[31:16] : rd[15:0];
            r = (sg && h[15]) ? {16'hFFFF, h} : {16'h0, h};
         end
         L_WORD: r = rd;
         L_LEFT:
            for (int i = 0; i < 4; i++)
               r[i*8 +: 8] = (i >= 3 - a) ? byte_of(rd, i - (3 - a)) : byte_of(rt, i);
         L_RIGHT:
            for (int i = 0; i < 4; i++)
               r[i*8 +: 8] = (i <= 3 - a) ? byte_of(rd, i + a) : byte_of(rt, i);
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (resp_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_resp_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("resp_data_o", data_o, e.data);
               check("resp_bus_err", {31'd0, bus_err}, {31'd0, e.err});
            end
         end else if (bus_err) begin
            check("bus_err_outside_resp", {31'd0, bus_err}, 32'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic access(input logic [1:0] ty, input logic [2:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] d,
                         input logic [31:0] rd, input int nwait);
      int   a = int'(addr[1:0]);
      logic is_acc = (ty == T_M2R) || (ty == T_R2M);
      logic mis = is_acc && (((sz == L_HALF) && addr[0]) ||
                             ((sz == L_WORD) && (addr[1:0] != 2'b00)));
      logic [4:0] ra = 5'($urandom);
      exp_t e;
      @(negedge clk);
      mem_access_type   = ty;
      mem_access_size   = sz;
      mem_access_signed = sg;
      mem_access_addr_i = addr;
      data_i            = d;
      reg_addr_i        = ra;
      bus_ack           = 1'b0;
      #1;
      check("alignment_err", {31'd0, alignment_err}, {31'd0, mis});
      check("bypass_reg_addr", {27'd0, bypass_reg_addr_mm}, {27'd0, ra});
      if (!is_acc || mis) begin
         check("stall_no_access", {31'd0, stall}, 32'd0);
         check("pass_through", data_o, d);
         @(posedge clk);
         #1;
         check("no_strobes", {30'd0, bus_read, bus_write}, 32'd0);
         mem_access_type = T_NONE;
         return;
      end
      check("stall_accept", {31'd0, stall}, 32'd1);
      e.err  = (nwait >= int'(TIMEOUT));
      e.data = e.err ? 32'h0 : ((ty == T_M2R) ? model_load(sz, sg, a, d, rd) : d);
      exp_q.push_back(e);
      @(posedge clk);
      for (int c = 0; c < int'(TIMEOUT); c++) begin
         @(negedge clk);
         if (c == 0) begin
            check("bus_read", {31'd0, bus_read}, {31'd0, ty == T_M2R});
            check("bus_write", {31'd0, bus_write}, {31'd0, ty == T_R2M});
            check("bus_addr", bus_addr, {addr[31:2], 2'b00});
            if (sz <= L_RIGHT) check("bus_be", {28'd0, bus_be}, {28'd0, model_be(sz, a)});
            if (ty == T_R2M && sz <= L_RIGHT)
               check("bus_wdata", bus_wdata, model_wdata(sz, a, d));
         end
         check("stall_wait", {31'd0, stall}, 32'd1);
         // New data_i during WAIT must not disturb the latched request.
         data_i = $urandom;
         #1;
         check("pass_through_wait", data_o, data_i);
         if (c == nwait) begin
            bus_ack   = 1'b1;
            bus_rdata = rd;
         end else begin
            bus_rdata = $urandom;
         end
         @(posedge clk);
         #1;
         bus_ack = 1'b0;
         if (c == nwait) break;
      end
      @(negedge clk);
      // Request inputs are still presented here; they must not be re-accepted.
      check("resp_valid_latency", {31'd0, resp_valid}, 32'd1);
      check("stall_resp", {31'd0, stall}, 32'd0);
      check("strobes_cleared", {30'd0, bus_read, bus_write}, 32'd0);
      @(posedge clk);
      #1;
      check("no_reaccept", {30'd0, bus_read, bus_write}, 32'd0);
      mem_access_type = T_NONE;
   endtask

   task automatic reset_mid_access();
      @(negedge clk);
      mem_access_type   = T_M2R;
      mem_access_size   = L_WORD;
      mem_access_addr_i = 32'h0000_0100;
      @(posedge clk);
      @(negedge clk);
      check("rst_pre_bus_read", {31'd0, bus_read}, 32'd1);
      mem_access_type = T_NONE;
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_bus_read", {31'd0, bus_read}, 32'd0);
      check("rst_async_bus_addr", bus_addr, 32'h0);
      check("rst_async_stall", {31'd0, stall}, 32'd0);
      bus_ack = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ack_ignored_resp", {31'd0, resp_valid}, 32'd0);
      check("rst_ack_ignored_stall", {31'd0, stall}, 32'd0);
      bus_ack = 1'b0;
   endtask

   initial begin
      #2;
      check("reset_bus_read", {31'd0, bus_read}, 32'd0);
      check("reset_bus_write", {31'd0, bus_write}, 32'd0);
      check("reset_bus_be", {28'd0, bus_be}, 32'd0);
      check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("reset_stall", {31'd0, stall}, 32'd0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      access(T_M2R, L_WORD,  1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0);
      access(T_M2R, L_BYTE,  1'b1, 32'h0000_0103, 32'h0,         32'h8012_3456, 3);
      access(T_M2R, L_BYTE,  1'b0, 32'h0000_0103, 32'h0,         32'h8012_3456, 3);
      access(T_R2M, L_HALF,  1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0,         1);
      access(T_R2M, L_BYTE,  1'b0, 32'h0000_0201, 32'h0000_0055, 32'h0,         0);
      access(T_M2R, L_LEFT,  1'b0, 32'h0000_0001, 32'h1122_3344, 32'hAABB_CCDD, 2);
      access(T_M2R, L_RIGHT, 1'b0, 32'h0000_0002, 32'h1122_3344, 32'hAABB_CCDD, 0);
      access(T_M2R, L_WORD,  1'b0, 32'h0000_0102, 32'h7777_0000, 32'h0,         0);
      access(T_NONE, L_WORD, 1'b0, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,         0);
      access(T_M2R, L_WORD,  1'b0, 32'h0000_0300, 32'h0,         32'h1111_2222, 16);
      access(T_R2M, L_WORD,  1'b0, 32'h0000_0304, 32'h3333_4444, 32'h0,         16);
      access(T_M2R, L_WORD,  1'b0, 32'h0000_0308, 32'h0,         32'h5555_6666, 15);
      reset_mid_access();

      for (int n = 0; n < 150; n++) begin
         int nw = $urandom_range(0, 5);
         if ($urandom_range(0, 19) == 0) nw = ($urandom_range(0, 1) == 0) ? 15 : 16;
         access(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom),
                $urandom, $urandom, $urandom, nw);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mm_ctrl.md
# mm_ctrl

Multi-cycle memory-stage controller for the 5-stage MIPS pipeline. It sits between ex and wb and issues one registered load or store per instruction to a handshaked data bus, holding the pipeline with `stall` until the bus acknowledges. It formats load data for byte, half, word, LWL and LWR, and replicates store data with byte enables. Unlike a single-cycle memory stage, it tolerates variable bus latency and reports a bus timeout.

## Interface
- `TIMEOUT`, default 16: number of WAIT cycles without `bus_ack` before the access is aborted. Legal range is 2..255.
- `CNT_W`, default 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_access_type` in 2: `MEM_ACCESS_TYPE_*` from defs.v (M2R = load, R2M = store, other = no access).
- `mem_access_size` in 3: `MEM_ACCESS_LENGTH_*` (BYTE, HALF, WORD, LEFT_WORD, RIGHT_WORD).
- `mem_access_signed` in 1: sign-extend byte and half loads.
- `mem_access_addr_i` in 32: byte address from ex.
- `data_i` in 32: store data, LWL/LWR merge source (rt), or pass-through value.
- `reg_addr_i` in 5: destination register.
- `data_o` out 32: result to wb and bypass mux.
- `bypass_reg_addr_mm` out 5: equals `reg_addr_i`.
- `stall` out 1: freeze ex/mm pipeline registers.
- `resp_valid` out 1: one-cycle pulse when a memory access completes.
- `alignment_err` out 1: combinational. HALF with addr[0]≠0, or WORD with addr[1:0]≠0, on a load or store.
- `bus_err` out 1: one-cycle pulse on timeout.
- `bus_addr` out 32: registered. Word-aligned (addr[1:0] forced to 0).
- `bus_wdata` out 32: registered.
- `bus_be` out 4: registered byte enables.
- `bus_read` out 1: registered.
- `bus_write` out 1: registered.
- `bus_rdata` in 32: valid in the `bus_ack` cycle.
- `bus_ack` in 1: completes the current access.

## Operation
- `start` = (type is M2R or R2M) and !`alignment_err` and state is IDLE.
- **IDLE**
  - On `start`: latch type, size, signed, addr[1:0] and `data_i`; drive the bus registers; go to WAIT.
  - Otherwise the bus registers hold `bus_read`=`bus_write`=0.
- **WAIT**
  - Hold the bus registers. The counter increments every cycle `bus_ack`=0.
  - `bus_ack`=1: clear `bus_read`/`bus_write`; capture the formatted load result (or the latched `data_i` for stores) into `resp_q`; go to RESP.
  - Counter reaches TIMEOUT-1 with no ack: clear the bus, set `resp_q`=0, pulse `bus_err`, go to RESP.
  - If `bus_ack` and timeout coincide, the ack wins and there is no `bus_err`.
- **RESP**
  - `resp_valid`=1 for this cycle, then go to IDLE unconditionally.
  - Inputs still presented in RESP are never re-accepted.
- **Byte enables**
  - BYTE: one-hot on addr[1:0].
  - HALF: 0011 or 1100 by addr[1].
  - WORD: 1111.
  - LEFT_WORD: {a1&a0, a1, a1|a0, 1}.
  - RIGHT_WORD: {1, ~(a1&a0), ~a1, ~(a1|a0)}.
  - Byte enables apply to both reads and writes.
- **Store data**
  - BYTE: the byte replicated ×4.
  - HALF: the half replicated ×2.
  - WORD: as is.
  - SWL: `data_i` >> ((3-a)·8).
  - SWR: `data_i` << (a·8).
- **Load data**
  - BYTE/HALF: select the lane, then sign- or zero-extend per `signed`.
  - WORD: as is.
  - LWL: (rdata << ((3-a)·8)) | (rt & ~(FFFFFFFF << ((3-a)·8))).
  - LWR: (rdata >> (a·8)) | (rt & ~(FFFFFFFF >> (a·8))).
  - Any other size: 0.
- **`data_o` selection**
  - RESP: `resp_q`.
  - Otherwise: `data_i` (pass-through for ALU ops).
- **`stall`** = `start` | (state==WAIT).
- **Misaligned access**: no bus access and no stall; `data_o`=`data_i`. Exception handling is outside this block.

## Timing
- **Reset** (async, immediate): state IDLE, counter 0, `resp_q`=0.
  - `bus_read`=`bus_write`=0, `bus_addr`=0, `bus_wdata`=0, `bus_be`=0.
  - `resp_valid`=`bus_err`=0.
  - `stall` and `data_o` follow the combinational rules (0 and `data_i` with no access pending).
- **Access cycles**
  - Accept cycle T: `stall`=1.
  - Bus signals are visible from T+1.
  - Ack in cycle T+k (k≥1): RESP at T+k+1, with `stall`=0 and `resp_valid`=1.
  - Minimum latency from accept to RESP is 2 cycles.
- **Reset mid-access** drops the bus strobes immediately; a pending ack is ignored.
- `bus_ack` outside WAIT is ignored.

## Test plan
- **LW, zero wait**: LW to 0x100, ack at T+1 with rdata 0xDEADBEEF → `bus_be`=1111, `bus_addr`=0x100, RESP at T+2, `data_o`=0xDEADBEEF, `stall` high for 2 cycles.
- **LB signed, 3 waits**: LB signed, addr 0x103, rdata 0x80xxxxxx, ack after 3 waits → `bus_be`=1000, `data_o`=0xFFFFFF80. LBU at the same address → 0x00000080.
- **SH and SB**: SH addr 0x202, `data_i`=0x1234ABCD → `bus_write`=1, `bus_be`=1100, `bus_wdata`=0xABCDABCD, `data_o`=0x1234ABCD in RESP. SB addr 0x201, `data_i`=0x55 → `bus_be`=0010, `bus_wdata`=0x55555555.
- **LWL/LWR merge**: rt=0x11223344, rdata=0xAABBCCDD.
  - LWL addr 1 → `bus_be`=0011, `data_o`=0xCCDD3344.
  - LWR addr 2 → `bus_be`=1100, `data_o`=0x1122AABB.
- **Misaligned and pass-through**:
  - LW at addr 0x102 → `alignment_err`=1, `bus_read` never asserts, `stall`=0.
  - Type none → `data_o`=`data_i` the same cycle.
- **Timeout and reset**:
  - No ack with TIMEOUT=16 → `bus_err` pulses in the RESP cycle 17 cycles after accept, `data_o`=0.
  - Ack in the final WAIT cycle → no `bus_err`.
  - `rst_n` low in WAIT → `bus_read`=0 asynchronously, state IDLE.
